// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the MIPS-subset op/func into an ALU code and operands,
// and captures the result in a stall/flush-aware pipeline register.
module alu_issue_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        d_valid,
    input  logic [5:0]  d_op,
    input  logic [5:0]  d_func,
    input  logic [4:0]  d_rt,
    input  logic [4:0]  d_rd,
    input  logic [4:0]  d_sa,
    input  logic [15:0] d_imm,
    input  logic [31:0] d_qa,
    input  logic [31:0] d_qb,
    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [31:0] ex_fwd_data,
    input  logic [31:0] mem_fwd_data,
    output logic        e_valid,
    output logic [2:0]  ealuc,
    output logic [31:0] alua,
    output logic [31:0] alub,
    output logic        e_wreg,
    output logic [4:0]  e_rn,
    output logic        e_m2reg,
    output logic        e_wmem,
    output logic [31:0] e_b,
    output logic        e_illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;

    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] sx;
    logic [31:0] zx;
    logic [31:0] sa_ext;

    logic [2:0]  dec_aluc;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_wreg;
    logic [4:0]  dec_rn;
    logic        dec_m2reg;
    logic        dec_wmem;
    logic        dec_illegal;

    // Select 11 falls back to the register file, same as 00.
    always_comb begin
        unique case (fwd_a)
            2'b01:   fa = ex_fwd_data;
            2'b10:   fa = mem_fwd_data;
            default: fa = d_qa;
        endcase
        unique case (fwd_b)
            2'b01:   fb = ex_fwd_data;
            2'b10:   fb = mem_fwd_data;
            default: fb = d_qb;
        endcase
    end

    assign sx     = {{16{d_imm[15]}}, d_imm};
    assign zx     = {16'b0, d_imm};
    assign sa_ext = {27'b0, d_sa};

    always_comb begin
        dec_aluc    = ALU_ADD;
        dec_a       = 32'b0;
        dec_b       = 32'b0;
        dec_wreg    = 1'b0;
        dec_rn      = 5'b0;
        dec_m2reg   = 1'b0;
        dec_wmem    = 1'b0;
        dec_illegal = 1'b0;
        if (d_op == OP_RTYPE) begin
            dec_a    = fa;
            dec_b    = fb;
            dec_rn   = d_rd;
            dec_wreg = 1'b1;
            unique case (d_func)
                FN_ADD: dec_aluc = ALU_ADD;
                FN_SUB: dec_aluc = ALU_SUB;
                FN_AND: dec_aluc = ALU_AND;
                FN_OR:  dec_aluc = ALU_OR;
                FN_XOR: dec_aluc = ALU_XOR;
                FN_SLL: begin
                    dec_aluc = ALU_SLL;
                    dec_a    = sa_ext;
                end
                FN_SRL: begin
                    dec_aluc = ALU_SRL;
                    dec_a    = sa_ext;
                end
                default: begin
                    dec_a       = 32'b0;
                    dec_b       = 32'b0;
                    dec_rn      = 5'b0;
                    dec_wreg    = 1'b0;
                    dec_illegal = 1'b1;
                end
            endcase
        end else begin
            dec_a    = fa;
            dec_rn   = d_rt;
            dec_wreg = 1'b1;
            unique case (d_op)
                OP_ADDI: begin dec_aluc = ALU_ADD; dec_b = sx; end
                OP_ANDI: begin dec_aluc = ALU_AND; dec_b = zx; end
                OP_ORI:  begin dec_aluc = ALU_OR;  dec_b = zx; end
                OP_XORI: begin dec_aluc = ALU_XOR; dec_b = zx; end
                OP_LUI: begin
                    dec_aluc = ALU_SLL;
                    dec_a    = 32'd16;
                    dec_b    = zx;
                end
                OP_LW: begin
                    dec_aluc  = ALU_ADD;
                    dec_b     = sx;
                    dec_m2reg = 1'b1;
                end
                // Address goes through the ALU; the store data travels on e_b.
                OP_SW: begin
                    dec_aluc = ALU_ADD;
                    dec_b    = sx;
                    dec_wmem = 1'b1;
                    dec_wreg = 1'b0;
                end
                default: begin
                    dec_a       = 32'b0;
                    dec_rn      = 5'b0;
                    dec_wreg    = 1'b0;
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // Flush beats stall so a squashed slot never lingers during a hazard hold.
    always_ff @(posedge clock) begin
        if (reset || flush || (!stall && !d_valid)) begin
            e_valid   <= 1'b0;
            ealuc     <= ALU_ADD;
            alua      <= 32'b0;
            alub      <= 32'b0;
            e_wreg    <= 1'b0;
            e_rn      <= 5'b0;
            e_m2reg   <= 1'b0;
            e_wmem    <= 1'b0;
            e_b       <= 32'b0;
            e_illegal <= 1'b0;
        end else if (!stall) begin
            e_valid   <= 1'b1;
            ealuc     <= dec_aluc;
            alua      <= dec_a;
            alub      <= dec_b;
            e_wreg    <= dec_wreg;
            e_rn      <= dec_rn;
            e_m2reg   <= dec_m2reg;
            e_wmem    <= dec_wmem;
            e_b       <= fb;
            e_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed vectors, literal checks, and a
// per-cycle comparison against a behavioural model of the E-stage slot.
module tb_alu_issue_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        d_valid;
    logic [5:0]  d_op;
    logic [5:0]  d_func;
    logic [4:0]  d_rt;
    logic [4:0]  d_rd;
    logic [4:0]  d_sa;
    logic [15:0] d_imm;
    logic [31:0] d_qa;
    logic [31:0] d_qb;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] ex_fwd_data;
    logic [31:0] mem_fwd_data;
    logic        e_valid;
    logic [2:0]  ealuc;
    logic [31:0] alua;
    logic [31:0] alub;
    logic        e_wreg;
    logic [4:0]  e_rn;
    logic        e_m2reg;
    logic        e_wmem;
    logic [31:0] e_b;
    logic        e_illegal;

    int tests = 0;
    int fails = 0;
    logic armed = 1'b0;

    typedef struct packed {
        logic        valid;
        logic [2:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic        wreg;
        logic [4:0]  rn;
        logic        m2reg;
        logic        wmem;
        logic [31:0] eb;
        logic        illegal;
    } slot_t;

    slot_t model;

    alu_issue_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .d_valid(d_valid), .d_op(d_op), .d_func(d_func), .d_rt(d_rt),
        .d_rd(d_rd), .d_sa(d_sa), .d_imm(d_imm), .d_qa(d_qa), .d_qb(d_qb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_data(mem_fwd_data), .e_valid(e_valid), .ealuc(ealuc),
        .alua(alua), .alub(alub), .e_wreg(e_wreg), .e_rn(e_rn),
        .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_b(e_b), .e_illegal(e_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val);
        if (sel == 2'd1) return ex_fwd_data;
        if (sel == 2'd2) return mem_fwd_data;
        return reg_val;
    endfunction

    // What the E slot must hold after this edge, from the instruction semantics.
    function automatic slot_t next_slot(input slot_t cur);
        slot_t s;
        logic [31:0] a_val, b_val, sext, zext;
        s = '0;
        if (reset || flush) return s;
        if (stall) return cur;
        if (!d_valid) return s;
        a_val = pick(fwd_a, d_qa);
        b_val = pick(fwd_b, d_qb);
        sext = {{16{d_imm[15]}}, d_imm};
        zext = {16'h0, d_imm};
        s.valid = 1'b1;
        s.eb = b_val;
        s.wreg = 1'b1;
        if (d_op == 6'd0) begin
            s.rn = d_rd;
            s.a = a_val;
            s.b = b_val;
            case (d_func)
                6'h20: s.aluc = 3'd0;
                6'h22: s.aluc = 3'd6;
                6'h24: s.aluc = 3'd1;
                6'h25: s.aluc = 3'd2;
                6'h26: s.aluc = 3'd3;
                6'h00: begin s.aluc = 3'd5; s.a = 32'(d_sa); end
                6'h02: begin s.aluc = 3'd4; s.a = 32'(d_sa); end
                default: s.illegal = 1'b1;
            endcase
        end else begin
            s.rn = d_rt;
            s.a = a_val;
            case (d_op)
                6'h08: s.b = sext;
                6'h0C: begin s.aluc = 3'd1; s.b = zext; end
                6'h0D: begin s.aluc = 3'd2; s.b = zext; end
                6'h0E: begin s.aluc = 3'd3; s.b = zext; end
                6'h0F: begin s.aluc = 3'd5; s.a = 32'd16; s.b = zext; end
                6'h23: begin s.b = sext; s.m2reg = 1'b1; end
                6'h2B: begin s.b = sext; s.wmem = 1'b1; s.wreg = 1'b0; end
                default: s.illegal = 1'b1;
            endcase
        end
        if (s.illegal) begin
            s.aluc = 3'd0; s.a = '0; s.b = '0; s.wreg = 1'b0; s.m2reg = 1'b0; s.wmem = 1'b0; s.rn = '0;
        end
        return s;
    endfunction

    always @(posedge clock) model <= next_slot(model);

    // The destination number of an illegal slot carries no meaning, so it is ignored.
    always @(negedge clock) begin
        if (armed) begin
            slot_t act;
            slot_t expv;
            act = {e_valid, ealuc, alua, alub, e_wreg, e_rn, e_m2reg, e_wmem, e_b, e_illegal};
            expv = model;
            if (expv.illegal) begin
                act.rn = '0;
                expv.rn = '0;
            end
            tests++;
            if (act !== expv) begin
                fails++;
                $display("[TB] FAIL model_cycle t=%0t actual=%h required=%h", $time, act, expv);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(
        input logic [5:0] op, input logic [5:0] func, input logic [4:0] rt, input logic [4:0] rd,
        input logic [4:0] sa, input logic [15:0] imm, input logic [31:0] qa, input logic [31:0] qb,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic v, input logic st, input logic fl, input logic rs);
        @(negedge clock);
        d_op = op; d_func = func; d_rt = rt; d_rd = rd; d_sa = sa; d_imm = imm;
        d_qa = qa; d_qb = qb; fwd_a = fa; fwd_b = fb;
        d_valid = v; stall = st; flush = fl; reset = rs;
        @(posedge clock);
        #1;
    endtask

    initial begin
        ex_fwd_data = 32'h0000_000F;
        mem_fwd_data = 32'hDEAD_BEEF;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; d_valid = 1'b1;
        d_op = '0; d_func = 6'h20; d_rt = 5'd2; d_rd = 5'd3; d_sa = '0; d_imm = '0;
        d_qa = 32'd5; d_qb = 32'd7; fwd_a = '0; fwd_b = '0;
        @(posedge clock);
        #1;
        armed = 1'b1;
        apply_stimulus(6'h00, 6'h20, 5'd2, 5'd3, 5'd0, 16'h1820, 32'd5, 32'd7, 2'd0, 2'd0, 1, 0, 0, 1);
        check_output("reset_valid", 32'(e_valid), 32'd0);
        check_output("reset_alua", alua, 32'd0);
        check_output("reset_wreg", 32'(e_wreg), 32'd0);

        apply_stimulus(6'h00, 6'h20, 5'd2, 5'd3, 5'd0, 16'h1820, 32'd5, 32'd7, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("add_aluc", 32'(ealuc), 32'd0);
        check_output("add_alua", alua, 32'd5);
        check_output("add_alub", alub, 32'd7);
        check_output("add_rn", 32'(e_rn), 32'd3);
        check_output("add_wreg", 32'(e_wreg), 32'd1);

        apply_stimulus(6'h08, 6'h3F, 5'd4, 5'd31, 5'd31, 16'hFFFF, 32'd9, 32'd1, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("addi_alub", alub, 32'hFFFF_FFFF);
        apply_stimulus(6'h0D, 6'h3F, 5'd4, 5'd31, 5'd31, 16'hFFFF, 32'd9, 32'd1, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("ori_alub", alub, 32'h0000_FFFF);
        check_output("ori_aluc", 32'(ealuc), 32'd2);
        apply_stimulus(6'h0F, 6'h34, 5'd6, 5'd2, 5'd8, 16'h1234, 32'd9, 32'd1, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("lui_aluc", 32'(ealuc), 32'd5);
        check_output("lui_alua", alua, 32'd16);
        check_output("lui_alub", alub, 32'h0000_1234);

        apply_stimulus(6'h00, 6'h00, 5'd2, 5'd7, 5'd4, 16'h3900, 32'd9, 32'd1, 2'd0, 2'd1, 1, 0, 0, 0);
        check_output("sll_aluc", 32'(ealuc), 32'd5);
        check_output("sll_alua", alua, 32'd4);
        check_output("sll_alub", alub, 32'h0000_000F);
        apply_stimulus(6'h2B, 6'h04, 5'd5, 5'd16, 5'd0, 16'h8004, 32'h100, 32'd1, 2'd0, 2'd2, 1, 0, 0, 0);
        check_output("sw_eb", e_b, 32'hDEAD_BEEF);
        check_output("sw_wmem", 32'(e_wmem), 32'd1);
        check_output("sw_wreg", 32'(e_wreg), 32'd0);
        check_output("sw_alub", alub, 32'hFFFF_8004);

        apply_stimulus(6'h00, 6'h02, 5'd1, 5'd9, 5'd3, 16'h0000, 32'd1, 32'h80, 2'd3, 2'd3, 1, 0, 0, 0);
        apply_stimulus(6'h00, 6'h26, 5'd1, 5'd9, 5'd0, 16'h0000, 32'h55, 32'hFF, 2'd2, 2'd0, 1, 0, 0, 0);
        apply_stimulus(6'h00, 6'h24, 5'd1, 5'd9, 5'd0, 16'h0000, 32'h55, 32'hFF, 2'd0, 2'd0, 1, 0, 0, 0);
        apply_stimulus(6'h00, 6'h25, 5'd1, 5'd9, 5'd0, 16'h0000, 32'h55, 32'hFF, 2'd1, 2'd0, 1, 0, 0, 0);
        apply_stimulus(6'h23, 6'h00, 5'd8, 5'd0, 5'd0, 16'hFFFC, 32'h200, 32'd0, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("lw_m2reg", 32'(e_m2reg), 32'd1);
        apply_stimulus(6'h0C, 6'h00, 5'd8, 5'd0, 5'd0, 16'h8001, 32'h200, 32'd0, 2'd0, 2'd0, 1, 0, 0, 0);
        apply_stimulus(6'h0E, 6'h00, 5'd8, 5'd0, 5'd0, 16'hA5A5, 32'h200, 32'd0, 2'd0, 2'd0, 1, 0, 0, 0);

        apply_stimulus(6'h00, 6'h22, 5'd2, 5'd10, 5'd0, 16'h5022, 32'd20, 32'd8, 2'd0, 2'd0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(6'h08, 6'h00, 5'(i), 5'(i + 1), 5'd1, 16'(i * 7), 32'(i + 100), 32'd3, 2'd0, 2'd0, 1, 1, 0, 0);
            check_output("stall_aluc", 32'(ealuc), 32'd6);
            check_output("stall_alua", alua, 32'd20);
            check_output("stall_rn", 32'(e_rn), 32'd10);
        end
        apply_stimulus(6'h08, 6'h00, 5'd1, 5'd1, 5'd1, 16'h0001, 32'd1, 32'd1, 2'd0, 2'd0, 1, 1, 1, 0);
        check_output("flush_valid", 32'(e_valid), 32'd0);
        check_output("flush_alua", alua, 32'd0);

        apply_stimulus(6'h3F, 6'h20, 5'd1, 5'd2, 5'd0, 16'h0000, 32'd1, 32'd2, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("illegal_set", 32'(e_illegal), 32'd1);
        check_output("illegal_wreg", 32'(e_wreg), 32'd0);
        apply_stimulus(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 16'h0000, 32'd1, 32'd2, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("illegal_clear", 32'(e_illegal), 32'd0);
        apply_stimulus(6'h00, 6'h3F, 5'd1, 5'd2, 5'd0, 16'h0000, 32'd1, 32'd2, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("bad_func", 32'(e_illegal), 32'd1);
        apply_stimulus(6'h3F, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0000, 32'd1, 32'd2, 2'd0, 2'd0, 1, 1, 0, 0);
        check_output("illegal_held", 32'(e_illegal), 32'd1);
        apply_stimulus(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 16'h0000, 32'd1, 32'd2, 2'd0, 2'd0, 1, 0, 1, 0);
        check_output("illegal_flushed", 32'(e_illegal), 32'd0);

        apply_stimulus(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 16'h0000, 32'd1, 32'd2, 2'd0, 2'd0, 0, 0, 0, 0);
        check_output("dvalid0_valid", 32'(e_valid), 32'd0);
        apply_stimulus(6'h00, 6'h20, 5'd1, 5'd4, 5'd0, 16'h0000, 32'd11, 32'd2, 2'd0, 2'd0, 1, 0, 0, 0);
        apply_stimulus(6'h00, 6'h20, 5'd1, 5'd4, 5'd0, 16'h0000, 32'd11, 32'd2, 2'd0, 2'd0, 1, 1, 0, 1);
        check_output("reset_in_stall", 32'(e_valid), 32'd0);
        apply_stimulus(6'h00, 6'h20, 5'd1, 5'd4, 5'd0, 16'h0000, 32'd11, 32'd2, 2'd0, 2'd0, 1, 0, 0, 0);
        check_output("final_alua", alua, 32'd11);

        @(negedge clock);
        #1;
        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
